calc_alu: RTL and testbench
===========================

# calc_alu

Parametrised multi-operation arithmetic unit for the UART calculator datapath. Sits between the command parser and the result formatter: operands and opcode are captured on a one-cycle start pulse, the result is computed (single-step for ADD/SUB, iterative for MUL/DIV) and announced with a one-cycle done pulse. It replaces the single-function add/subtract blocks with one block that is generic in operand width and adds multiply, divide and error reporting.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; result width is 2*WIDTH; legal range 4..32.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request pulse from the parser; accepted only while idle.
- op  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- src1  in  WIDTH  first operand, unsigned.
- src2  in  WIDTH  second operand, unsigned.
- busy  out  1  high from the cycle after acceptance up to and including the done cycle.
- done  out  1  one-cycle pulse; calc_res and err are valid and stable from this cycle.
- calc_res  out  2*WIDTH  result register.
- err  out  1  divide-by-zero flag, registered with calc_res.

## Operation
- States: IDLE, EXEC, ITER, DONE.
- IDLE: on start=1, latch op, src1, src2; go to EXEC. start=0: stay.
- EXEC: ADD/SUB: write calc_res, err=0, go to DONE. MUL: init accumulator and counter, go to ITER. DIV with src2=0: calc_res = all ones, err=1, go to DONE. DIV otherwise: init remainder/quotient and counter, go to ITER.
- ITER: exactly WIDTH iterations (counter WIDTH-1 down to 0); on last iteration write calc_res, err=0, go to DONE.
- DONE: done=1; go to IDLE.
- Arithmetic rules:
  - ADD: zero-extended sum; carry lands in bit WIDTH.
  - SUB: two's-complement src1-src2 sign-extended to 2*WIDTH (3-5 gives all ones except LSB=0).
  - MUL: unsigned shift-add product, full 2*WIDTH.
  - DIV: unsigned restoring division; calc_res[WIDTH-1:0] = quotient, calc_res[2*WIDTH-1:WIDTH] = remainder.
- start while busy: ignored, no queueing, latched operands unaffected.
- start in the DONE cycle: ignored (accepted only in IDLE).
- Changing src1/src2/op after acceptance has no effect.
- calc_res and err hold their value between operations; only overwritten at result write.

## Timing
- Reset values: state IDLE, busy 0, done 0, calc_res 0, err 0, internal counter/accumulators 0.
- Start accepted at edge T0 (start high in the cycle before T0).
- ADD/SUB and DIV-by-zero: calc_res written at T1; done high in cycle after T1 (latency 2 edges, matching previous add/sub blocks).
- MUL/DIV: calc_res written at T(1+WIDTH); done high in the following cycle (latency WIDTH+2 edges; 18 for WIDTH=16).
- Back-to-back: next start may be accepted at the edge ending the done cycle+1, i.e. earliest when state is IDLE again.
- Reset mid-operation: immediate return to IDLE; all outputs to reset values; no done pulse for the aborted operation.

## Structure
- Shared package calc_pkg: op encodings (OP_ADD/OP_SUB/OP_MUL/OP_DIV), state enum, shared by parser and formatter.
- One sub-module: calc_muldiv_iter (iterative shift-add multiplier / restoring divider with counter, load/step/last interface); FSM, operand latches and ADD/SUB stay in calc_alu.

## Test plan
- WIDTH=16, ADD 0xFFFF+0x0001 -> calc_res 0x00010000, err 0, done 2 edges after acceptance, busy high 2 cycles.
- SUB 0x0003-0x0005 -> calc_res 0xFFFFFFFE; SUB 0x1234-0x1234 -> 0x00000000.
- MUL 0xFFFF*0xFFFF -> 0xFFFE0001, done 18 edges after acceptance; MUL 0x0000*0x1234 -> 0x00000000.
- DIV 100/7 -> calc_res 0x0002000E, err 0, latency 18; DIV 5/0 -> calc_res 0xFFFFFFFF, err 1, latency 2; following ADD 1+1 clears err to 0.
- MUL 3*4 accepted, then start pulses with other ops/operands every cycle while busy -> single done, calc_res 0x0000000C; next start after IDLE accepted.
- Start MUL, assert n_rst low mid-ITER -> busy/done/calc_res/err 0 immediately, no done pulse after release; new ADD completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the UART calculator datapath: opcode encodings and ALU state enum.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StIter = 2'd2,
      StDone = 2'd3
   } alu_state_e;

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative engine: shift-add multiplier / restoring divider sharing one 2*WIDTH register.
// Layout of acc: MUL {partial high, multiplier remainder}, DIV {remainder, quotient}.
module calc_muldiv_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               last,
   output logic [2*WIDTH-1:0] res_next
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_diff;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? src2 : {WIDTH{1'b0}})};
      div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      // Bit WIDTH set means the trial subtraction borrowed: restore.
      div_diff = div_part - {1'b0, src2};
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load) begin
         acc_d = {{WIDTH{1'b0}}, src1};
         cnt_d = CntW'(WIDTH - 1);
      end else if (step) begin
         if (is_div) begin
            if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign last     = (cnt_q == '0);
   assign res_next = acc_d;

endmodule

// File: rtl/calc_alu.sv
// Multi-operation calculator ALU: ADD/SUB in one step, MUL/DIV via calc_muldiv_iter,
// divide-by-zero flagged on err. One request in flight; start only accepted while idle.
module calc_alu
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] calc_res,
   output logic               err
);

   alu_state_e         state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   src1_q, src1_d;
   logic [WIDTH-1:0]   src2_q, src2_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic               err_q, err_d;
   logic               it_load, it_step, it_last;
   logic [2*WIDTH-1:0] it_res;
   logic [WIDTH:0]     sub_diff;

   calc_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk     (clk),
      .n_rst   (n_rst),
      .load    (it_load),
      .step    (it_step),
      .is_div  (op_q == OP_DIV),
      .src1    (src1_q),
      .src2    (src2_q),
      .last    (it_last),
      .res_next(it_res)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      res_d    = res_q;
      err_d    = err_q;
      it_load  = 1'b0;
      it_step  = 1'b0;
      // Extra top bit carries the sign of the difference for sign extension.
      sub_diff = {1'b0, src1_q} - {1'b0, src2_q};
      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d    = op_e'(op);
               src1_d  = src1;
               src2_d  = src2;
               state_d = StExec;
            end
         end
         StExec: begin
            unique case (op_q)
               OP_ADD: begin
                  res_d   = {{WIDTH{1'b0}}, src1_q} + {{WIDTH{1'b0}}, src2_q};
                  err_d   = 1'b0;
                  state_d = StDone;
               end
               OP_SUB: begin
                  res_d   = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
                  err_d   = 1'b0;
                  state_d = StDone;
               end
               OP_MUL: begin
                  it_load = 1'b1;
                  state_d = StIter;
               end
               OP_DIV: begin
                  if (src2_q == '0) begin
                     res_d   = '1;
                     err_d   = 1'b1;
                     state_d = StDone;
                  end else begin
                     it_load = 1'b1;
                     state_d = StIter;
                  end
               end
            endcase
         end
         StIter: begin
            it_step = 1'b1;
            if (it_last) begin
               res_d   = it_res;
               err_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         op_q    <= OP_ADD;
         src1_q  <= '0;
         src2_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign calc_res = res_q;
   assign err      = err_q;

endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu (WIDTH=16): stimulus pushes expected results, a negedge
// monitor pops on each done pulse and checks result, err, latency and busy duration.
module tb_calc_alu;

   localparam int unsigned W = 16;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op = 2'd0;
   logic [W-1:0]   src1 = '0;
   logic [W-1:0]   src2 = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] calc_res;
   logic           err;

   typedef struct {
      logic [2*W-1:0] res;
      logic           err;
      int             lat;
      int             acc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   busy_run = 0;
   logic [2*W-1:0] last_res = '0;

   calc_alu #(
      .WIDTH(W)
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .start   (start),
      .op      (op),
      .src1    (src1),
      .src2    (src2),
      .busy    (busy),
      .done    (done),
      .calc_res(calc_res),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitor: compares each done pulse against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (busy) busy_run = busy_run + 1;
      else busy_run = 0;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("calc_res", 64'(calc_res), 64'(e.res));
            check("err", 64'(err), 64'(e.err));
            check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            check("busy_cycles", 64'(busy_run), 64'(e.lat));
            last_res = e.res;
         end
      end
   end

   task automatic issue_raw(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src1  = a;
      src2  = b;
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] r, input logic e, input int lat);
      exp_t x;
      issue_raw(o, a, b);
      x.res = r;
      x.err = e;
      x.lat = lat;
      x.acc = cyc + 1;
      exp_q.push_back(x);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, 64'd1, 64'd0);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      check({name, "_hold"}, 64'(calc_res), 64'(last_res));
   endtask

   initial begin
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_res", 64'(calc_res), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;

      issue(2'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2);
      wait_done("add_carry");
      issue(2'd1, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 2);
      wait_done("sub_neg");
      issue(2'd1, 16'h1234, 16'h1234, 32'h0000_0000, 1'b0, 2);
      wait_done("sub_zero");
      issue(2'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 18);
      wait_done("mul_max");
      issue(2'd2, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 18);
      wait_done("mul_zero");
      issue(2'd3, 16'd100, 16'd7, 32'h0002_000E, 1'b0, 18);
      wait_done("div");
      issue(2'd3, 16'd5, 16'd0, 32'hFFFF_FFFF, 1'b1, 2);
      wait_done("div0");
      issue(2'd0, 16'd1, 16'd1, 32'h0000_0002, 1'b0, 2);
      wait_done("add_clr_err");

      // Hammer start while busy: must be ignored, operands must not change.
      issue(2'd2, 16'd3, 16'd4, 32'h0000_000C, 1'b0, 18);
      begin
         int k;
         k = 0;
         while (k < 40 && !(!busy && exp_q.size() == 0)) begin
            start = 1'b1;
            op    = 2'(k);
            src1  = 16'(k * 7 + 1);
            src2  = 16'(k + 9);
            @(negedge clk);
            k++;
         end
         start = 1'b0;
         if (k >= 40) check("busy_pulse_timeout", 64'd1, 64'd0);
      end
      wait_done("mul_pulsed");
      issue(2'd0, 16'd2, 16'd3, 32'h0000_0005, 1'b0, 2);
      wait_done("add_after_pulse");

      // Reset mid-ITER: no expectation pushed, so any done pulse is flagged.
      issue_raw(2'd2, 16'hFFFF, 16'hFFFF);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      n_rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_res", 64'(calc_res), 64'd0);
      check("abort_err", 64'(err), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      last_res = '0;
      repeat (25) @(negedge clk);
      check("abort_res_held", 64'(calc_res), 64'd0);
      issue(2'd0, 16'd7, 16'd8, 32'h0000_000F, 1'b0, 2);
      wait_done("add_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
